// File: rtl/irn_timeout_ctrl_pkg.sv
// Shared parameters, response payload type and helpers for the IRN timeout controller.
// Backoff support is compiled in with IRN_TIMEOUT_BACKOFF_EN.
package irn_timeout_ctrl_pkg;

    localparam int unsigned NUM_FLOWS      = 64;
    localparam int unsigned FLOW_ID_W      = 6;
    localparam int unsigned SEQ_W          = 32;
    localparam int unsigned WIN_IND_W      = 8;
    localparam int unsigned TIMER_W        = 16;
    localparam int unsigned RTO_LOW_THRESH = 3;
    localparam int unsigned MAX_BACKOFF    = 6;

    localparam logic [TIMER_W-1:0] RTO_LOW  = 16'd100;
    localparam logic [TIMER_W-1:0] RTO_HIGH = 16'd400;

    // Ceiling log2; clogb2(7) = 3.
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = 32'(i + 1);
        end
        return r;
    endfunction

    localparam int unsigned BACKOFF_W = clogb2(MAX_BACKOFF + 1);

    // Sequence-space subtraction, modulo 2^SEQ_W.
    function automatic logic [SEQ_W-1:0] seq_diff(input logic [SEQ_W-1:0] a,
                                                  input logic [SEQ_W-1:0] b);
        return a - b;
    endfunction

    typedef struct packed {
        logic [FLOW_ID_W-1:0] flow_id;
        logic                 mark_rtx;
        logic                 in_recovery;
        logic [SEQ_W-1:0]     rtx_start;
        logic [SEQ_W-1:0]     rtx_end;
        logic [SEQ_W-1:0]     recovery_seq;
        logic [TIMER_W-1:0]   rtx_timer_amnt;
        logic [BACKOFF_W-1:0] backoff;
    } rsp_t;

endpackage

// File: rtl/irn_timeout_ctrl_if.sv
// Timeout event, ACK-clear and response signals of the IRN timeout controller.
interface irn_timeout_ctrl_if;
    import irn_timeout_ctrl_pkg::*;

    logic                 to_valid;
    logic                 to_ready;
    logic [FLOW_ID_W-1:0] to_flow_id;
    logic [SEQ_W-1:0]     to_wnd_start;
    logic [SEQ_W-1:0]     to_next_new;
    logic [SEQ_W-1:0]     to_max_sack;
    logic [WIN_IND_W-1:0] to_acked_cnt;
    logic                 clr_valid;
    logic [FLOW_ID_W-1:0] clr_flow_id;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [FLOW_ID_W-1:0] rsp_flow_id;
    logic                 rsp_mark_rtx;
    logic                 rsp_in_recovery;
    logic [SEQ_W-1:0]     rsp_rtx_start;
    logic [SEQ_W-1:0]     rsp_rtx_end;
    logic [SEQ_W-1:0]     rsp_recovery_seq;
    logic [TIMER_W-1:0]   rsp_rtx_timer_amnt;
    logic [BACKOFF_W-1:0] rsp_backoff;

    modport master (
        output to_valid, to_flow_id, to_wnd_start, to_next_new, to_max_sack, to_acked_cnt,
        output clr_valid, clr_flow_id, rsp_ready,
        input  to_ready, rsp_valid, rsp_flow_id, rsp_mark_rtx, rsp_in_recovery,
        input  rsp_rtx_start, rsp_rtx_end, rsp_recovery_seq, rsp_rtx_timer_amnt, rsp_backoff
    );

    modport slave (
        input  to_valid, to_flow_id, to_wnd_start, to_next_new, to_max_sack, to_acked_cnt,
        input  clr_valid, clr_flow_id, rsp_ready,
        output to_ready, rsp_valid, rsp_flow_id, rsp_mark_rtx, rsp_in_recovery,
        output rsp_rtx_start, rsp_rtx_end, rsp_recovery_seq, rsp_rtx_timer_amnt, rsp_backoff
    );

endinterface

// File: rtl/irn_backoff_table.sv
// Per-flow saturating backoff exponent table: one read port, one increment port, one clear port.
// A clear and an increment on the same flow in one cycle resolve as clear, then increment.
module irn_backoff_table
    import irn_timeout_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLOW_ID_W-1:0] rd_id,
    output logic [BACKOFF_W-1:0] rd_data,
    input  logic                 inc_en,
    input  logic [FLOW_ID_W-1:0] inc_id,
    input  logic                 clr_en,
    input  logic [FLOW_ID_W-1:0] clr_id
);

    logic [BACKOFF_W-1:0] tab_q [NUM_FLOWS];
    logic [BACKOFF_W-1:0] tab_d [NUM_FLOWS];
    logic [BACKOFF_W-1:0] entry;

    assign rd_data = (32'(rd_id) < NUM_FLOWS) ? tab_q[rd_id] : '0;

    always_comb begin
        entry = '0;
        for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
            entry = tab_q[i];
            if (clr_en && (32'(clr_id) == i)) entry = '0;
            if (inc_en && (32'(inc_id) == i)) begin
                entry = (entry >= BACKOFF_W'(MAX_BACKOFF)) ? BACKOFF_W'(MAX_BACKOFF)
                                                           : entry + BACKOFF_W'(1);
            end
            tab_d[i] = entry;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
            if (rst) tab_q[i] <= '0;
            else     tab_q[i] <= tab_d[i];
        end
    end

endmodule

// File: rtl/irn_timeout_ctrl.sv
// IRN retransmission-timeout controller: one registered response per accepted timeout event.
// Define IRN_TIMEOUT_BACKOFF_EN to enable the per-flow exponential backoff table.
module irn_timeout_ctrl
    import irn_timeout_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    irn_timeout_ctrl_if.slave  bus
);

    localparam int unsigned AMNT_W = TIMER_W + (32'd1 << BACKOFF_W);
    localparam logic [SEQ_W-1:0] INFL_MAX = SEQ_W'((32'd1 << WIN_IND_W) - 1);

    logic                 accept;
    logic                 nonempty;
    logic [SEQ_W-1:0]     out_cnt;
    logic [SEQ_W-1:0]     infl_raw;
    logic [SEQ_W-1:0]     sack_off;
    logic [WIN_IND_W-1:0] infl;
    logic [TIMER_W-1:0]   base_rto;
    logic [AMNT_W-1:0]    amnt_wide;
    logic [BACKOFF_W-1:0] bo;
    rsp_t                 rsp_new;
    rsp_t                 rsp_d, rsp_q;
    logic                 rsp_valid_d, rsp_valid_q;

    assign accept = bus.to_valid && bus.to_ready;

`ifdef IRN_TIMEOUT_BACKOFF_EN
    logic                 flow_ok;
    logic [BACKOFF_W-1:0] tab_rd;

    assign flow_ok = 32'(bus.to_flow_id) < NUM_FLOWS;

    irn_backoff_table u_backoff_table (
        .clk     (clk),
        .rst     (rst),
        .rd_id   (bus.to_flow_id),
        .rd_data (tab_rd),
        .inc_en  (accept && nonempty && flow_ok),
        .inc_id  (bus.to_flow_id),
        .clr_en  (bus.clr_valid),
        .clr_id  (bus.clr_flow_id)
    );

    // A same-cycle clear of this flow wins over the stored exponent.
    always_comb begin
        bo = tab_rd;
        if (!flow_ok || (bus.clr_valid && (bus.clr_flow_id == bus.to_flow_id))) bo = '0;
    end
`else
    logic unused_clr;
    assign unused_clr = ^{bus.clr_valid, bus.clr_flow_id};
    assign bo = '0;
`endif

    always_comb begin
        out_cnt   = seq_diff(bus.to_next_new, bus.to_wnd_start);
        nonempty  = (out_cnt != '0);
        infl_raw  = seq_diff(out_cnt, SEQ_W'(bus.to_acked_cnt));
        infl      = (infl_raw > INFL_MAX) ? '1 : infl_raw[WIN_IND_W-1:0];
        base_rto  = (infl > WIN_IND_W'(RTO_LOW_THRESH)) ? RTO_HIGH : RTO_LOW;
        amnt_wide = AMNT_W'(base_rto) << bo;
        sack_off  = seq_diff(bus.to_max_sack, bus.to_wnd_start);

        rsp_new.flow_id        = bus.to_flow_id;
        rsp_new.mark_rtx       = nonempty;
        rsp_new.in_recovery    = nonempty;
        rsp_new.rtx_start      = bus.to_wnd_start;
        // SACK outside (0, out] is stale or wrapped: retransmit only the head.
        rsp_new.rtx_end        = ((sack_off != '0) && (sack_off <= out_cnt))
                                 ? bus.to_max_sack : bus.to_wnd_start + SEQ_W'(1);
        rsp_new.recovery_seq   = bus.to_next_new;
        rsp_new.rtx_timer_amnt = (|amnt_wide[AMNT_W-1:TIMER_W]) ? '1 : amnt_wide[TIMER_W-1:0];
        rsp_new.backoff        = bo;
    end

    // Output register: load on accept, hold while stalled, drop valid on handshake.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_d       = rsp_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.to_ready           = !rsp_valid_q || bus.rsp_ready;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_flow_id        = rsp_q.flow_id;
    assign bus.rsp_mark_rtx       = rsp_q.mark_rtx;
    assign bus.rsp_in_recovery    = rsp_q.in_recovery;
    assign bus.rsp_rtx_start      = rsp_q.rtx_start;
    assign bus.rsp_rtx_end        = rsp_q.rtx_end;
    assign bus.rsp_recovery_seq   = rsp_q.recovery_seq;
    assign bus.rsp_rtx_timer_amnt = rsp_q.rtx_timer_amnt;
    assign bus.rsp_backoff        = rsp_q.backoff;

endmodule

// File: tb/tb_irn_timeout_ctrl.sv
// Directed bench for irn_timeout_ctrl; expectations follow IRN_TIMEOUT_BACKOFF_EN when defined.
module tb_irn_timeout_ctrl;
    import irn_timeout_ctrl_pkg::*;

`ifdef IRN_TIMEOUT_BACKOFF_EN
    localparam bit BO_EN = 1'b1;
`else
    localparam bit BO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   ntests;
    int   nfail;

    irn_timeout_ctrl_if bus ();

    irn_timeout_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ev(input int flow, input logic [31:0] ws, input logic [31:0] nn,
                          input int acked, input logic [31:0] ms);
        bus.to_flow_id   = FLOW_ID_W'(flow);
        bus.to_wnd_start = ws;
        bus.to_next_new  = nn;
        bus.to_acked_cnt = WIN_IND_W'(acked);
        bus.to_max_sack  = ms;
    endtask

    initial begin
        int exp_bo [8];
        int bo_e;
        exp_bo = '{0, 1, 2, 3, 4, 5, 6, 6};
        ntests = 0;
        nfail  = 0;
        rst = 1'b1;
        bus.to_valid = 1'b0;
        bus.clr_valid = 1'b0;
        bus.clr_flow_id = '0;
        bus.rsp_ready = 1'b1;
        set_ev(0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_end", 64'(bus.rsp_rtx_end), 64'd0);
        check("rst_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd0);
        check("rst_bo", 64'(bus.rsp_backoff), 64'd0);
        check("rst_ready", 64'(bus.to_ready), 64'd1);
        tick();
        check("rst_ready_next", 64'(bus.to_ready), 64'd1);

        // Basic timeout, infl = 8 -> high RTO
        set_ev(3, 100, 110, 2, 105);
        bus.to_valid = 1'b1;
        tick();
        bus.to_valid = 1'b0;
        check("t1_valid", 64'(bus.rsp_valid), 64'd1);
        check("t1_flow", 64'(bus.rsp_flow_id), 64'd3);
        check("t1_mark", 64'(bus.rsp_mark_rtx), 64'd1);
        check("t1_inrec", 64'(bus.rsp_in_recovery), 64'd1);
        check("t1_start", 64'(bus.rsp_rtx_start), 64'd100);
        check("t1_end", 64'(bus.rsp_rtx_end), 64'd105);
        check("t1_rec", 64'(bus.rsp_recovery_seq), 64'd110);
        check("t1_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd400);
        check("t1_bo", 64'(bus.rsp_backoff), 64'd0);

        // Eight back-to-back timeouts on flow 5, infl = 1
        set_ev(5, 1000, 1001, 0, 1001);
        bus.to_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            bo_e = BO_EN ? exp_bo[k] : 0;
            check($sformatf("bb%0d_valid", k), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("bb%0d_ready", k), 64'(bus.to_ready), 64'd1);
            check($sformatf("bb%0d_bo", k), 64'(bus.rsp_backoff), 64'(bo_e));
            check($sformatf("bb%0d_amnt", k), 64'(bus.rsp_rtx_timer_amnt), 64'(100 << bo_e));
            check($sformatf("bb%0d_end", k), 64'(bus.rsp_rtx_end), 64'd1001);
        end
        bus.to_valid = 1'b0;

        // Clear alone, then a timeout sees bo = 0
        bus.clr_valid = 1'b1;
        bus.clr_flow_id = 6'd5;
        tick();
        bus.clr_valid = 1'b0;
        check("clr_drain_valid", 64'(bus.rsp_valid), 64'd0);
        bus.to_valid = 1'b1;
        tick();
        bus.to_valid = 1'b0;
        check("post_clr_bo", 64'(bus.rsp_backoff), 64'd0);
        check("post_clr_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd100);

        // Same-cycle clear and timeout: bo = 0, table ends at 1
        bus.clr_valid = 1'b1;
        bus.to_valid = 1'b1;
        tick();
        bus.clr_valid = 1'b0;
        check("clr_same_bo", 64'(bus.rsp_backoff), 64'd0);
        check("clr_same_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd100);
        tick();
        bus.to_valid = 1'b0;
        check("clr_same_next_bo", 64'(bus.rsp_backoff), BO_EN ? 64'd1 : 64'd0);
        check("clr_same_next_amnt", 64'(bus.rsp_rtx_timer_amnt), BO_EN ? 64'd200 : 64'd100);

        // Threshold and in-flight saturation on fresh flows
        set_ev(7, 10, 13, 0, 13);
        bus.to_valid = 1'b1;
        tick();
        check("infl3_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd100);
        check("infl3_end", 64'(bus.rsp_rtx_end), 64'd13);
        set_ev(8, 10, 14, 0, 14);
        tick();
        check("infl4_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd400);
        set_ev(10, 10, 12, 5, 11);
        tick();
        check("infl_sat_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd400);
        check("infl_sat_end", 64'(bus.rsp_rtx_end), 64'd11);

        // Sequence wrap: SACK outside window, then inside window across wrap
        set_ev(9, 32'hFFFF_FFFE, 32'd2, 0, 32'd5);
        tick();
        check("wrap_end", 64'(bus.rsp_rtx_end), 64'hFFFF_FFFF);
        check("wrap_mark", 64'(bus.rsp_mark_rtx), 64'd1);
        check("wrap_start", 64'(bus.rsp_rtx_start), 64'hFFFF_FFFE);
        check("wrap_rec", 64'(bus.rsp_recovery_seq), 64'd2);
        check("wrap_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd400);
        set_ev(12, 32'hFFFF_FFFE, 32'd2, 0, 32'd1);
        tick();
        check("wrap_in_end", 64'(bus.rsp_rtx_end), 64'd1);

        // Empty flow 5 (table = 2 when enabled): no mark, table unchanged
        set_ev(5, 500, 500, 0, 500);
        tick();
        check("empty_mark", 64'(bus.rsp_mark_rtx), 64'd0);
        check("empty_inrec", 64'(bus.rsp_in_recovery), 64'd0);
        check("empty_end", 64'(bus.rsp_rtx_end), 64'd501);
        check("empty_bo", 64'(bus.rsp_backoff), BO_EN ? 64'd2 : 64'd0);
        check("empty_amnt", 64'(bus.rsp_rtx_timer_amnt), BO_EN ? 64'd400 : 64'd100);
        set_ev(5, 500, 501, 0, 501);
        tick();
        bus.to_valid = 1'b0;
        check("after_empty_mark", 64'(bus.rsp_mark_rtx), 64'd1);
        check("after_empty_bo", 64'(bus.rsp_backoff), BO_EN ? 64'd2 : 64'd0);
        tick();
        check("drain_valid", 64'(bus.rsp_valid), 64'd0);

        // Backpressure: three stalled cycles hold the response and deassert to_ready
        bus.rsp_ready = 1'b0;
        set_ev(20, 3000, 3010, 0, 3004);
        bus.to_valid = 1'b1;
        tick();
        check("stall_valid", 64'(bus.rsp_valid), 64'd1);
        check("stall_ready", 64'(bus.to_ready), 64'd0);
        set_ev(21, 4000, 4002, 0, 4001);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_valid", k), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("stall%0d_ready", k), 64'(bus.to_ready), 64'd0);
            check($sformatf("stall%0d_flow", k), 64'(bus.rsp_flow_id), 64'd20);
            check($sformatf("stall%0d_start", k), 64'(bus.rsp_rtx_start), 64'd3000);
            check($sformatf("stall%0d_end", k), 64'(bus.rsp_rtx_end), 64'd3004);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("unstall_ready", 64'(bus.to_ready), 64'd1);
        tick();
        bus.to_valid = 1'b0;
        check("unstall_flow", 64'(bus.rsp_flow_id), 64'd21);
        check("unstall_start", 64'(bus.rsp_rtx_start), 64'd4000);
        check("unstall_end", 64'(bus.rsp_rtx_end), 64'd4001);
        tick();
        check("unstall_drain", 64'(bus.rsp_valid), 64'd0);

        // Reset with a pending response drops it and clears the table
        bus.rsp_ready = 1'b0;
        set_ev(5, 600, 610, 0, 605);
        bus.to_valid = 1'b1;
        tick();
        bus.to_valid = 1'b0;
        check("pend_valid", 64'(bus.rsp_valid), 64'd1);
        rst = 1'b1;
        bus.clr_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.clr_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        check("pend_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("pend_rst_start", 64'(bus.rsp_rtx_start), 64'd0);
        check("pend_rst_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd0);
        bus.to_valid = 1'b1;
        tick();
        bus.to_valid = 1'b0;
        check("post_rst_bo", 64'(bus.rsp_backoff), 64'd0);
        check("post_rst_amnt", 64'(bus.rsp_rtx_timer_amnt), 64'd400);
        check("post_rst_end", 64'(bus.rsp_rtx_end), 64'd605);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
